// File: rtl/noise_gate.sv
// noise_gate: sample-rate noise gate ahead of the distortion stage.
// Peak envelope follower, hysteresis thresholds, hold timer and linear
// attack/release gain ramps in Q(bits_per_level) fixed point.
// Optional macro NOISE_GATE_METER_EN adds the env_level meter output.
module noise_gate #(
  parameter int unsigned bits_per_level = 12,
  parameter int unsigned HOLD_SAMPLES   = 480,
  parameter int unsigned DECAY_SHIFT    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic signed [15:0] in_signal,
  input  logic        [15:0] open_thresh,
  input  logic        [15:0] close_thresh,
  input  logic        [15:0] attack_step,
  input  logic        [15:0] release_step,
  output logic               out_valid,
  output logic signed [15:0] out_signal,
  output logic               gate_open
`ifdef NOISE_GATE_METER_EN
  ,
  output logic        [15:0] env_level
`endif
);

  localparam int unsigned DataW = 16;
  localparam int unsigned GainW = bits_per_level + 1;
  localparam int unsigned SumW  = ((GainW > DataW) ? GainW : DataW) + 1;
  localparam int unsigned HoldW = (HOLD_SAMPLES < 2) ? 1 : $clog2(HOLD_SAMPLES + 1);
  localparam int unsigned ProdW = 32;

  localparam logic [GainW-1:0] Unity = {1'b1, {bits_per_level{1'b0}}};

  typedef enum logic [2:0] {
    ST_CLOSED,
    ST_ATTACK,
    ST_OPEN,
    ST_HOLD,
    ST_RELEASE
  } state_e;

  state_e                    state_q, state_d;
  logic        [DataW-1:0]   env_q;
  logic        [GainW-1:0]   gain_q, gain_d;
  logic        [HoldW-1:0]   hold_q, hold_d;
  logic signed [DataW-1:0]   x_q;
  logic                      valid_q;
  logic                      gate_open_q;
  logic                      out_valid_q;
  logic signed [DataW-1:0]   out_signal_q;

  logic [DataW-1:0] abs_x;
  logic [DataW-1:0] env_dec;
  logic [DataW-1:0] env_next;
  logic [DataW-1:0] atk_step;
  logic [DataW-1:0] rel_step;
  logic [SumW-1:0]  gain_sum;
  logic [GainW-1:0] gain_up;
  logic [GainW-1:0] gain_dn;

  // Magnitude of the incoming sample; the most negative code clips to 32767
  always_comb begin
    abs_x = in_signal;
    if (in_signal == 16'sh8000) begin
      abs_x = 16'h7fff;
    end else if (in_signal[DataW-1]) begin
      abs_x = DataW'(-in_signal);
    end
  end

  // Peak envelope: instant attack, proportional release with a floor of one LSB
  always_comb begin
    env_dec = env_q >> DECAY_SHIFT;
    if (env_dec == '0) begin
      env_dec = DataW'(1);
    end
    if (abs_x >= env_q) begin
      env_next = abs_x;
    end else if (env_q != '0) begin
      env_next = env_q - env_dec;
    end else begin
      env_next = '0;
    end
  end

  // Saturating gain ramps; a zero step behaves as a single-LSB step
  always_comb begin
    atk_step = (attack_step == '0) ? DataW'(1) : attack_step;
    rel_step = (release_step == '0) ? DataW'(1) : release_step;
    gain_sum = SumW'(gain_q) + SumW'(atk_step);
    gain_up  = (gain_sum >= SumW'(Unity)) ? Unity : GainW'(gain_sum);
    gain_dn  = (SumW'(gain_q) > SumW'(rel_step)) ?
               GainW'(SumW'(gain_q) - SumW'(rel_step)) : '0;
  end

  // Gate state machine: next state, gain and hold counter
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_CLOSED: begin
        gain_d = '0;
        if (env_next >= open_thresh) begin
          state_d = ST_ATTACK;
          gain_d  = gain_up;
        end
      end
      ST_ATTACK: begin
        gain_d = gain_up;
        if (env_next < close_thresh) begin
          state_d = ST_RELEASE;
        end else if (gain_up == Unity) begin
          state_d = ST_OPEN;
        end
      end
      ST_OPEN: begin
        gain_d = Unity;
        if (env_next < close_thresh) begin
          state_d = ST_HOLD;
          hold_d  = HoldW'(HOLD_SAMPLES);
        end
      end
      ST_HOLD: begin
        gain_d = Unity;
        if (env_next >= open_thresh) begin
          state_d = ST_OPEN;
        end else if (hold_q <= HoldW'(1)) begin
          state_d = ST_RELEASE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q - HoldW'(1);
        end
      end
      ST_RELEASE: begin
        if (env_next >= open_thresh) begin
          state_d = ST_ATTACK;
          gain_d  = gain_up;
        end else begin
          gain_d = gain_dn;
          if (gain_dn == '0) begin
            state_d = ST_CLOSED;
          end
        end
      end
      default: begin
        state_d = ST_CLOSED;
        gain_d  = '0;
        hold_d  = '0;
      end
    endcase
  end

  // Stage 1: capture sample, envelope, state and gain on each input strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_CLOSED;
      env_q       <= '0;
      gain_q      <= '0;
      hold_q      <= '0;
      x_q         <= '0;
      gate_open_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        state_q     <= state_d;
        env_q       <= env_next;
        gain_q      <= gain_d;
        hold_q      <= hold_d;
        x_q         <= in_signal;
        gate_open_q <= (state_d != ST_CLOSED);
      end
    end
  end

  // Stage 2: apply gain; gain never exceeds unity so the result always fits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_signal_q <= '0;
    end else begin
      out_valid_q <= valid_q;
      if (valid_q) begin
        out_signal_q <= DataW'((ProdW'(x_q) * $signed(ProdW'(gain_q))) >>> bits_per_level);
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_signal = out_signal_q;
  assign gate_open  = gate_open_q;

`ifdef NOISE_GATE_METER_EN
  assign env_level = env_q;
`endif

endmodule

// File: tb/tb_noise_gate.sv
// Self-checking bench for noise_gate: behavioural gate model feeding a
// scoreboard queue, plus fixed expected values for the key scenarios.
module tb_noise_gate;

  localparam int DS    = 1;
  localparam int HS    = 4;
  localparam int BPL   = 12;
  localparam int UNITY = 4096;

  localparam int M_CLOSED  = 0;
  localparam int M_ATTACK  = 1;
  localparam int M_OPEN    = 2;
  localparam int M_HOLD    = 3;
  localparam int M_RELEASE = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic signed [15:0] in_signal;
  logic        [15:0] open_thresh;
  logic        [15:0] close_thresh;
  logic        [15:0] attack_step;
  logic        [15:0] release_step;
  logic               out_valid;
  logic signed [15:0] out_signal;
  logic               gate_open;
`ifdef NOISE_GATE_METER_EN
  logic        [15:0] env_level;
`endif

  noise_gate #(
    .bits_per_level(BPL),
    .HOLD_SAMPLES  (HS),
    .DECAY_SHIFT   (DS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_signal   (in_signal),
    .open_thresh (open_thresh),
    .close_thresh(close_thresh),
    .attack_step (attack_step),
    .release_step(release_step),
    .out_valid   (out_valid),
    .out_signal  (out_signal),
    .gate_open   (gate_open)
`ifdef NOISE_GATE_METER_EN
    ,
    .env_level   (env_level)
`endif
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     val;
    longint cyc;
  } exp_t;

  exp_t exp_q[$];
  int   obs_q[$];
  int   checks = 0;
  int   errors = 0;

  int m_state, m_env, m_gain, m_hold;

  task automatic model_reset();
    m_state = M_CLOSED;
    m_env   = 0;
    m_gain  = 0;
    m_hold  = 0;
  endtask

  // Reference gate behaviour for one sample; returns expected output
  task automatic model_step(input int x, output int e);
    int ax, en, d, as, rs;
    longint p;
    ax = (x < 0) ? -x : x;
    if (ax > 32767) ax = 32767;
    if (ax >= m_env) en = ax;
    else begin
      d = m_env >> DS;
      if (d < 1) d = 1;
      en = m_env - d;
    end
    as = (attack_step == 0) ? 1 : int'(attack_step);
    rs = (release_step == 0) ? 1 : int'(release_step);
    case (m_state)
      M_CLOSED: begin
        m_gain = 0;
        if (en >= int'(open_thresh)) begin
          m_state = M_ATTACK;
          m_gain  = (as > UNITY) ? UNITY : as;
        end
      end
      M_ATTACK: begin
        m_gain = (m_gain + as > UNITY) ? UNITY : m_gain + as;
        if (en < int'(close_thresh)) m_state = M_RELEASE;
        else if (m_gain == UNITY) m_state = M_OPEN;
      end
      M_OPEN: begin
        m_gain = UNITY;
        if (en < int'(close_thresh)) begin
          m_state = M_HOLD;
          m_hold  = HS;
        end
      end
      M_HOLD: begin
        m_gain = UNITY;
        if (en >= int'(open_thresh)) m_state = M_OPEN;
        else begin
          m_hold = m_hold - 1;
          if (m_hold <= 0) m_state = M_RELEASE;
        end
      end
      default: begin
        if (en >= int'(open_thresh)) begin
          m_state = M_ATTACK;
          m_gain  = (m_gain + as > UNITY) ? UNITY : m_gain + as;
        end else begin
          m_gain = (m_gain - rs < 0) ? 0 : m_gain - rs;
          if (m_gain == 0) m_state = M_CLOSED;
        end
      end
    endcase
    m_env = en;
    p = longint'(x) * longint'(m_gain);
    e = int'(p >>> BPL);
  endtask

  task automatic set_cfg(input int op, input int cl, input int at, input int rl);
    open_thresh  = 16'(op);
    close_thresh = 16'(cl);
    attack_step  = 16'(at);
    release_step = 16'(rl);
  endtask

  // Drive one sample (called #1 after a rising edge), push its expectation
  task automatic send(input int x);
    int   e;
    exp_t t;
    in_signal = 16'(x);
    in_valid  = 1'b1;
    model_step(x, e);
    t.val = e;
    t.cyc = cyc;
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    checks++;
    if (gate_open !== (m_state != M_CLOSED)) begin
      errors++;
      $display("FAIL gate_open x=%0d got %b exp %b", x, gate_open, (m_state != M_CLOSED));
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain timeout pending=%0d exp 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b1;
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_obs(input string name, input int idx, input int expv);
    checks++;
    if (idx >= obs_q.size()) begin
      errors++;
      $display("FAIL %s[%0d] got none exp %0d", name, idx, expv);
    end else if (obs_q[idx] != expv) begin
      errors++;
      $display("FAIL %s[%0d] got %0d exp %0d", name, idx, obs_q[idx], expv);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_signal = '0;
    set_cfg(2000, 1000, 1024, 2048);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    if (out_signal !== 16'sd0) begin errors++; $display("FAIL rst_out_signal got %0d exp 0", out_signal); end
    if (gate_open !== 1'b0) begin errors++; $display("FAIL rst_gate_open got %b exp 0", gate_open); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_silence();
    set_cfg(2000, 1000, 1024, 2048);
    obs_q.delete();
    for (int i = 0; i < 100; i++) begin
      send(0);
      idle(int'($urandom_range(0, 2)));
    end
    drain();
    checks++;
    if (obs_q.size() != 100) begin
      errors++;
      $display("FAIL silence_count got %0d exp 100", obs_q.size());
    end
  endtask

  task automatic test_attack();
    set_cfg(2000, 1000, 1024, 2048);
    obs_q.delete();
    for (int i = 0; i < 6; i++) send(10000);
    drain();
    check_obs("attack", 0, 2500);
    check_obs("attack", 1, 5000);
    check_obs("attack", 2, 7500);
    check_obs("attack", 3, 10000);
    check_obs("attack", 4, 10000);
    check_obs("attack", 5, 10000);
  endtask

  task automatic test_hold_release();
    set_cfg(2000, 1000, 1024, 2048);
    for (int i = 0; i < 8; i++) send(0);
    checks++;
    if (gate_open !== 1'b1) begin errors++; $display("FAIL hold_open got %b exp 1", gate_open); end
    send(0);
    checks++;
    if (gate_open !== 1'b1) begin errors++; $display("FAIL release_open got %b exp 1", gate_open); end
    send(0);
    checks++;
    if (gate_open !== 1'b0) begin errors++; $display("FAIL closed_after_release got %b exp 0", gate_open); end
    drain();
  endtask

  task automatic test_reattack();
    set_cfg(2000, 1000, 1024, 2048);
    for (int i = 0; i < 4; i++) send(10000);
    for (int i = 0; i < 9; i++) send(0);
    drain();
    obs_q.delete();
    send(8000);
    drain();
    check_obs("reattack", 0, 6000);
    checks++;
    if (gate_open !== 1'b1) begin errors++; $display("FAIL reattack_open got %b exp 1", gate_open); end
  endtask

  task automatic test_full_scale();
    obs_q.delete();
    send(8000);
    send(-32768);
    send(32767);
    drain();
    check_obs("fullscale", 0, 8000);
    check_obs("fullscale", 1, -32768);
    check_obs("fullscale", 2, 32767);
`ifdef NOISE_GATE_METER_EN
    checks++;
    if (env_level !== 16'd32767) begin
      errors++;
      $display("FAIL env_level got %0d exp 32767", env_level);
    end
`endif
  endtask

  task automatic test_zero_step();
    do_reset();
    set_cfg(100, 50, 0, 0);
    obs_q.delete();
    for (int i = 0; i < 3; i++) send(32767);
    drain();
    check_obs("zerostep", 0, 7);
    check_obs("zerostep", 1, 15);
    check_obs("zerostep", 2, 23);
  endtask

  task automatic test_back_to_back();
    int x;
    do_reset();
    set_cfg(3000, 1500, 700, 300);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) x = int'($urandom_range(0, 65535)) - 32768;
      else x = int'($urandom_range(0, 1000)) - 500;
      send(x);
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    drain();
  endtask

  task automatic test_mid_reset();
    do_reset();
    set_cfg(2000, 1000, 1024, 2048);
    send(10000);
    send(10000);
    in_valid = 1'b0;
    rst      = 1'b1;
    exp_q.delete();
    model_reset();
    #1;
    checks += 3;
    if (out_signal !== 16'sd0) begin errors++; $display("FAIL midrst_out_signal got %0d exp 0", out_signal); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b exp 0", out_valid); end
    if (gate_open !== 1'b0) begin errors++; $display("FAIL midrst_gate_open got %b exp 0", gate_open); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    obs_q.delete();
    send(0);
    send(10000);
    drain();
    check_obs("postrst", 0, 0);
    check_obs("postrst", 1, 2500);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    fork
      forever begin
        exp_t t;
        @(negedge clk);
        if (!rst && out_valid) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out_valid got 1 exp 0 out=%0d", out_signal);
          end else begin
            t = exp_q.pop_front();
            obs_q.push_back(int'(out_signal));
            if (int'(out_signal) != t.val) begin
              errors++;
              $display("FAIL out_signal got %0d exp %0d", out_signal, t.val);
            end
            checks++;
            if (cyc - t.cyc != 2) begin
              errors++;
              $display("FAIL latency got %0d exp 2", cyc - t.cyc);
            end
          end
        end
      end
    join_none
    test_reset();
    test_silence();
    test_attack();
    test_hold_release();
    test_reattack();
    test_full_scale();
    test_zero_step();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
